wash_cycle_controller: RTL and testbench
========================================

Name: wash_cycle_controller

Overview:
- Main sequencing FSM of the washing machine; sits directly upstream of the period timer.
- Walks a paid cycle through FILL -> WASH -> RINSE -> SPIN.
- Per phase: loads timer_period, clears and enables the timer, and advances when timer_done is seen.
- Drives the water valve, motor and door lock, handles pause, door-open and cancel, and reports completion.

Parameters:
- FILL_TIME, 4'd2, timer_period value for FILL.
- WASH_TIME, 4'd5, timer_period value for WASH.
- RINSE_TIME, 4'd2, timer_period value for RINSE.
- SPIN_TIME, 4'd1, timer_period value for SPIN.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- coin_in  input  1  level; payment present.
- door_closed  input  1  1 = door shut.
- pause  input  1  level; freezes the current phase.
- cancel  input  1  level; abort request.
- double_wash  input  1  extra WASH+RINSE pass (macro only; ignored otherwise).
- timer_done  input  1  sticky done from timer.
- timer_clear  output  1  one-cycle timer reset pulse.
- timer_en  output  1  timer enable.
- timer_period  output  4  period for the current phase.
- state  output  3  IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4.
- water_valve  output  1  high in FILL and RINSE.
- motor_on  output  1  high in WASH, RINSE, SPIN.
- door_lock  output  1  high in any non-IDLE state.
- cycle_done  output  1  one-cycle pulse at SPIN completion.

Behaviour:
- Reset (async, any time, including mid-phase): state=IDLE, arm=0, all outputs 0, timer_period=0, pass counter=0.
- Outputs are registered. water_valve, motor_on and door_lock decode from the registered state.
- IDLE -> FILL on the first clk edge where coin_in=1 and door_closed=1.
  - coin_in with the door open: stay in IDLE.
- Every timed-state entry takes one ARM cycle:
  - timer_clear=1, timer_en=0, timer_period=phase value.
  - timer_done is ignored during ARM, because it is stale and sticky.
- RUN, from the next cycle onward: timer_clear=0, timer_en=1, timer_period held.
  - On the first edge with timer_done=1 in RUN, move to the next state's ARM.
  - Sequence: FILL->WASH->RINSE->SPIN->IDLE.
- Hold: in RUN, pause=1 or door_closed=0 forces timer_en=0; state and timer are held.
  - The phase resumes on release with no re-ARM.
  - In ARM the hold delays leaving ARM; timer_clear stays asserted while held.
  - door_closed=0 in SPIN holds the same way.
- Cancel, while not in IDLE or SPIN: go to SPIN ARM next edge (drain/spin-out), regardless of timer_done.
  - Cancel wins over a simultaneous timer_done.
  - Cancel in SPIN is ignored.
- SPIN completion: timer_done in RUN -> IDLE, with cycle_done=1 for exactly that one cycle.
  - door_lock drops in the same cycle.
- coin_in held high in IDLE after completion starts a new cycle on the next edge. The bench must deassert coin_in if that is not wanted.
- A pause asserted on the same edge as timer_done: hold wins, no advance. The sticky done is consumed after release.
- Latency: timer_done high in RUN -> new state visible 1 cycle later; timer_clear for the next phase is asserted in that same cycle.

Optional Feature:
- Macro: DOUBLE_WASH_EN.
- Defined:
  - double_wash is sampled at IDLE->FILL into a pass flag.
  - If the flag is set, the first RINSE completion goes to WASH ARM, not SPIN. A 1-bit pass counter allows exactly one repeat.
  - The flag clears on return to IDLE or on reset.
  - Cancel still goes straight to SPIN.
- Not defined:
  - double_wash is unconnected internally and the pass counter is absent.
  - The sequence is always single-pass.

Test Plan:
- Reset mid-WASH RUN (pause high) -> next cycle state=0; timer_en, timer_clear, door_lock, motor_on all 0.
- coin_in=1, door_closed=1, timer_done pulsed 3 cycles after each timer_en rise:
  - states 1,2,3,4,0 in order.
  - timer_period sequence 2,5,2,1.
  - one timer_clear pulse per phase.
  - cycle_done high exactly 1 cycle.
- coin_in=1 with door_closed=0 -> state stays 0. Close the door -> FILL next edge.
- In WASH RUN, drive pause=1 for 5 cycles with timer_done=1 held -> state=2 and timer_en=0 throughout. Release -> RINSE ARM on the next edge.
- cancel=1 together with timer_done=1 in FILL RUN -> state=4, timer_period=1, timer_clear=1. Then timer_done -> IDLE, cycle_done=1.
- With DOUBLE_WASH_EN and double_wash=1 at start -> states 1,2,3,2,3,4,0. Without the macro, the same stimulus -> 1,2,3,4,0.

Source files
------------

// File: rtl/wash_cycle_controller.sv
// wash_cycle_controller: washer sequencer FILL->WASH->RINSE->SPIN driving the period timer and actuators.
// Define DOUBLE_WASH_EN to allow one extra WASH+RINSE pass requested by double_wash at start.
module wash_cycle_controller #(
    parameter logic [3:0] FILL_TIME  = 4'd2,
    parameter logic [3:0] WASH_TIME  = 4'd5,
    parameter logic [3:0] RINSE_TIME = 4'd2,
    parameter logic [3:0] SPIN_TIME  = 4'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_in,
    input  logic       door_closed,
    input  logic       pause,
    input  logic       cancel,
    input  logic       double_wash,
    input  logic       timer_done,
    output logic       timer_clear,
    output logic       timer_en,
    output logic [3:0] timer_period,
    output logic [2:0] state,
    output logic       water_valve,
    output logic       motor_on,
    output logic       door_lock,
    output logic       cycle_done
);
    typedef enum logic [2:0] {IDLE = 3'd0, FILL = 3'd1, WASH = 3'd2, RINSE = 3'd3, SPIN = 3'd4} state_t;
    state_t state_q, tgt_d;
    logic arm_q, clear_q, en_q, done_q, hold, repeat_wash, enter_d;
    logic [3:0] period_q, period_d;
`ifdef DOUBLE_WASH_EN
    logic dbl_q, pass_q;
    assign repeat_wash = dbl_q && !pass_q;
`else
    logic unused_double_wash;
    assign unused_double_wash = double_wash;
    assign repeat_wash = 1'b0;
`endif
    assign hold = pause || !door_closed;
    // Cancel outranks both hold and timer_done; ARM ignores the stale sticky done.
    always_comb begin
        tgt_d = state_q == IDLE ? FILL :
                (cancel && state_q != SPIN) ? SPIN :
                state_q == FILL ? WASH :
                state_q == WASH ? RINSE :
                state_q == RINSE ? (repeat_wash ? WASH : SPIN) : IDLE;
        enter_d = state_q == IDLE ? coin_in && door_closed :
                  (cancel && state_q != SPIN) || (!hold && !arm_q && timer_done);
        period_d = tgt_d == FILL ? FILL_TIME : tgt_d == WASH ? WASH_TIME :
                   tgt_d == RINSE ? RINSE_TIME : tgt_d == SPIN ? SPIN_TIME : 4'd0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            arm_q    <= 1'b0;
            clear_q  <= 1'b0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
            period_q <= 4'd0;
`ifdef DOUBLE_WASH_EN
            dbl_q    <= 1'b0;
            pass_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (enter_d) begin
                state_q  <= tgt_d;
                arm_q    <= tgt_d != IDLE;
                clear_q  <= tgt_d != IDLE;
                en_q     <= 1'b0;
                period_q <= period_d;
                done_q   <= tgt_d == IDLE;
            end else if (state_q != IDLE) begin
                arm_q   <= arm_q && hold;
                clear_q <= arm_q && hold;
                en_q    <= !hold;
            end
`ifdef DOUBLE_WASH_EN
            if (enter_d && state_q == IDLE) begin
                dbl_q  <= double_wash;
                pass_q <= 1'b0;
            end else if (enter_d && tgt_d == IDLE) begin
                dbl_q  <= 1'b0;
                pass_q <= 1'b0;
            end else if (enter_d && state_q == RINSE && tgt_d == WASH) begin
                pass_q <= 1'b1;
            end
`endif
        end
    end
    assign state        = state_q;
    assign timer_clear  = clear_q;
    assign timer_en     = en_q;
    assign timer_period = period_q;
    assign cycle_done   = done_q;
    assign water_valve  = state_q == FILL || state_q == RINSE;
    assign motor_on     = state_q == WASH || state_q == RINSE || state_q == SPIN;
    assign door_lock    = state_q != IDLE;
endmodule

// File: tb/tb_wash_cycle_controller.sv
// tb_wash_cycle_controller: directed and random checks of wash_cycle_controller against a phase-plan model.
module tb_wash_cycle_controller;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic coin_in = 1'b0, door_closed = 1'b0, pause = 1'b0, cancel = 1'b0;
    logic double_wash = 1'b0, timer_done = 1'b0;
    logic timer_clear, timer_en, water_valve, motor_on, door_lock, cycle_done;
    logic [3:0] timer_period;
    logic [2:0] state;
    int n_chk = 0;
    int n_fail = 0;
    int plan[$];
    int m_pos = 0;
    logic m_busy = 1'b0, m_fresh = 1'b0, m_en = 1'b0, m_done = 1'b0;
    int e_state;

    wash_cycle_controller dut (
        .clk(clk), .reset(reset), .coin_in(coin_in), .door_closed(door_closed),
        .pause(pause), .cancel(cancel), .double_wash(double_wash), .timer_done(timer_done),
        .timer_clear(timer_clear), .timer_en(timer_en), .timer_period(timer_period),
        .state(state), .water_valve(water_valve), .motor_on(motor_on),
        .door_lock(door_lock), .cycle_done(cycle_done)
    );

    always #5 clk = ~clk;

    function automatic void chk(string n, int a, int e);
        n_chk++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endfunction

    function automatic int per(int s);
        return s == 1 ? 2 : s == 2 ? 5 : s == 3 ? 2 : s == 4 ? 1 : 0;
    endfunction

    // Model: a cycle is a list of phases; each phase opens with one ARM cycle, then runs until done.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0; m_fresh <= 1'b0; m_en <= 1'b0; m_done <= 1'b0; m_pos <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (coin_in && door_closed) begin
                    plan <= '{1, 2, 3, 4};
`ifdef DOUBLE_WASH_EN
                    if (double_wash) plan <= '{1, 2, 3, 2, 3, 4};
`endif
                    m_busy <= 1'b1; m_pos <= 0; m_fresh <= 1'b1; m_en <= 1'b0;
                end
            end else if (cancel && plan[m_pos] != 4) begin
                m_pos <= plan.size() - 1; m_fresh <= 1'b1; m_en <= 1'b0;
            end else if (pause || !door_closed) begin
                m_en <= 1'b0;
            end else if (m_fresh) begin
                m_fresh <= 1'b0; m_en <= 1'b1;
            end else if (timer_done) begin
                if (m_pos == plan.size() - 1) begin
                    m_busy <= 1'b0; m_done <= 1'b1; m_en <= 1'b0; m_fresh <= 1'b0;
                end else begin
                    m_pos <= m_pos + 1; m_fresh <= 1'b1; m_en <= 1'b0;
                end
            end else begin
                m_en <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        e_state = m_busy ? plan[m_pos] : 0;
        chk("state", int'(state), e_state);
        chk("timer_clear", int'(timer_clear), int'(m_busy && m_fresh));
        chk("timer_en", int'(timer_en), int'(m_en));
        chk("timer_period", int'(timer_period), per(e_state));
        chk("cycle_done", int'(cycle_done), int'(m_done));
        chk("water_valve", int'(water_valve), int'(e_state == 1 || e_state == 3));
        chk("motor_on", int'(motor_on), int'(e_state >= 2));
        chk("door_lock", int'(door_lock), int'(e_state != 0));
    end

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        coin_in = 0; door_closed = 0; pause = 0; cancel = 0; double_wash = 0; timer_done = 0;
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic reach(input int st);
        int c;
        coin_in = 1; door_closed = 1; timer_done = 1;
        for (c = 0; c < 50; c++) begin
            @(negedge clk);
            if (state != 0) coin_in = 0;
            if (int'(state) == st && timer_en) break;
        end
        chk("reach_run", int'(int'(state) == st && timer_en), 1);
    endtask

    task automatic run_cycle(input logic dw, output int seq, output int pseq, output int clears, output int dones);
        logic prev_en, seen;
        int cnt;
        logic [2:0] last;
        seq = 0; pseq = 0; clears = 0; dones = 0; prev_en = 0; cnt = 0; last = 0; seen = 0;
        coin_in = 1; door_closed = 1; double_wash = dw; timer_done = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (state != last) begin seq = seq * 10 + int'(state); last = state; end
            if (timer_clear) begin clears++; pseq = pseq * 16 + int'(timer_period); end
            if (cycle_done) dones++;
            if (state != 0) coin_in = 0;
            cnt = (timer_en && !prev_en) ? 0 : cnt + 1;
            prev_en = timer_en;
            timer_done = timer_en && cnt == 2;
            if (seen && state == 0) break;
            seen = seen | (state != 0);
        end
        @(negedge clk);
        if (cycle_done) dones++;
        double_wash = 0;
    endtask

    initial begin
        int seq, pseq, clears, dones;
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        // Reset while held in WASH RUN
        reach(2);
        pause = 1;
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("rst_state", int'(state), 0);
        chk("rst_en", int'(timer_en), 0);
        chk("rst_clear", int'(timer_clear), 0);
        chk("rst_lock", int'(door_lock), 0);
        chk("rst_motor", int'(motor_on), 0);
        #2 reset = 1'b0;
        pause = 0; timer_done = 0;
        // Full single cycle
        run_cycle(1'b0, seq, pseq, clears, dones);
        chk("seq_single", seq, 12340);
        chk("period_seq", pseq, 'h2521);
        chk("clear_pulses", clears, 4);
        chk("done_pulses", dones, 1);
        // Door open blocks start
        do_reset();
        coin_in = 1; door_closed = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("door_open_idle", int'(state), 0);
        end
        door_closed = 1;
        @(negedge clk);
        chk("door_close_fill", int'(state), 1);
        coin_in = 0;
        // Pause beats a held timer_done
        do_reset();
        reach(2);
        pause = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("pause_state", int'(state), 2);
            chk("pause_en", int'(timer_en), 0);
        end
        pause = 0;
        @(negedge clk);
        chk("resume_rinse", int'(state), 3);
        chk("resume_clear", int'(timer_clear), 1);
        timer_done = 0;
        // Cancel beats timer_done in FILL RUN
        do_reset();
        reach(1);
        cancel = 1; timer_done = 1;
        @(negedge clk);
        chk("cancel_state", int'(state), 4);
        chk("cancel_period", int'(timer_period), 1);
        chk("cancel_clear", int'(timer_clear), 1);
        cancel = 0; timer_done = 0;
        for (int i = 0; i < 10 && !timer_en; i++) @(negedge clk);
        chk("spin_run", int'(timer_en), 1);
        timer_done = 1;
        @(negedge clk);
        chk("cancel_end_state", int'(state), 0);
        chk("cancel_end_done", int'(cycle_done), 1);
        timer_done = 0;
        // Double-wash request
        do_reset();
        run_cycle(1'b1, seq, pseq, clears, dones);
`ifdef DOUBLE_WASH_EN
        chk("seq_double", seq, 1232340);
`else
        chk("seq_double", seq, 12340);
`endif
        chk("double_done_pulses", dones, 1);
        // Randomized traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 399) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                #2 reset = 1'b0;
            end
            coin_in = $urandom_range(0, 3) == 0;
            door_closed = $urandom_range(0, 7) != 0;
            pause = $urandom_range(0, 7) == 0;
            cancel = $urandom_range(0, 31) == 0;
            double_wash = $urandom_range(0, 1) == 1;
            timer_done = $urandom_range(0, 2) == 0;
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
